// File: rtl/stream_merger.sv
// Two-channel stream merger: each input is buffered in a small FIFO with an
// address/id sequence checker, and a round-robin picker feeds one output register.
`ifndef ADDRESS_WIDTH
`define ADDRESS_WIDTH 32
`endif
`ifndef ID_WIDTH
`define ID_WIDTH 8
`endif

module stream_merger #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [`ADDRESS_WIDTH-1:0] in_address_1,
  input  logic [`ID_WIDTH-1:0]      in_id_1,
  input  logic                      in_valid_1,
  output logic                      out_stall_1,
  input  logic [`ADDRESS_WIDTH-1:0] in_address_2,
  input  logic [`ID_WIDTH-1:0]      in_id_2,
  input  logic                      in_valid_2,
  output logic                      out_stall_2,
  output logic [`ADDRESS_WIDTH-1:0] out_address,
  output logic [`ID_WIDTH-1:0]      out_id,
  output logic                      out_channel,
  output logic                      out_valid,
  input  logic                      in_ready,
  output logic                      err_seq_1,
  output logic                      err_seq_2,
  output logic [15:0]               beat_count
);

  localparam int AW = `ADDRESS_WIDTH;
  localparam int IW = `ID_WIDTH;
  localparam int BW = AW + IW;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic [1:0]    in_valid_arr;
  logic [1:0]    stall_arr;
  logic [1:0]    nonempty;
  logic [1:0]    pop_arr;
  logic [1:0]    err_arr;
  logic [BW-1:0] in_beat_arr [2];
  logic [BW-1:0] head_arr [2];

  logic [AW-1:0] out_address_reg;
  logic [IW-1:0] out_id_reg;
  logic          out_channel_reg;
  logic          out_valid_reg;
  logic          last_grant_reg;
  logic [15:0]   beat_count_reg;
  logic          load;

  assign in_valid_arr   = {in_valid_2, in_valid_1};
  assign in_beat_arr[0] = {in_id_1, in_address_1};
  assign in_beat_arr[1] = {in_id_2, in_address_2};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_chan
      logic [BW-1:0] mem_reg [FIFO_DEPTH];
      logic [PW-1:0] wr_ptr_reg;
      logic [PW-1:0] rd_ptr_reg;
      logic [CW-1:0] count_reg;
      logic [IW-1:0] expected_id_reg;
      logic [AW-1:0] expected_addr_reg;
      logic          err_reg;
      logic          push;

      // Stall depends only on registered occupancy, so a pop never frees a slot same-cycle.
      assign stall_arr[gi] = (count_reg == CW'(FIFO_DEPTH));
      assign push          = in_valid_arr[gi] & ~stall_arr[gi];
      assign nonempty[gi]  = (count_reg != '0);
      assign head_arr[gi]  = mem_reg[rd_ptr_reg];
      assign err_arr[gi]   = err_reg;

      always_ff @(posedge clk) begin
        if (!reset && push) begin
          mem_reg[wr_ptr_reg] <= in_beat_arr[gi];
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          wr_ptr_reg        <= '0;
          rd_ptr_reg        <= '0;
          count_reg         <= '0;
          expected_id_reg   <= '0;
          expected_addr_reg <= '0;
          err_reg           <= 1'b0;
        end else begin
          if (push) begin
            wr_ptr_reg <= wr_ptr_reg + PW'(1);
          end
          if (pop_arr[gi]) begin
            rd_ptr_reg <= rd_ptr_reg + PW'(1);
          end
          case ({push, pop_arr[gi]})
            2'b10:   count_reg <= count_reg + CW'(1);
            2'b01:   count_reg <= count_reg - CW'(1);
            default: count_reg <= count_reg;
          endcase
          // Checker resynchronises to each accepted beat, mismatched or not.
          if (push) begin
            if (in_beat_arr[gi] != {expected_id_reg, expected_addr_reg}) begin
              err_reg <= 1'b1;
            end
            expected_id_reg   <= in_beat_arr[gi][BW-1:AW] + IW'(1);
            expected_addr_reg <= in_beat_arr[gi][AW-1:0] + AW'(4);
          end
        end
      end
    end
  endgenerate

  assign load = ~out_valid_reg | in_ready;

  // Under contention the channel not granted last wins; otherwise take whichever is non-empty.
  always_comb begin
    pop_arr = 2'b00;
    if (load) begin
      if (nonempty == 2'b11) begin
        pop_arr = last_grant_reg ? 2'b01 : 2'b10;
      end else begin
        pop_arr = nonempty;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_address_reg <= '0;
      out_id_reg      <= '0;
      out_channel_reg <= 1'b0;
      out_valid_reg   <= 1'b0;
      last_grant_reg  <= 1'b1;
      beat_count_reg  <= '0;
    end else begin
      if (load) begin
        out_valid_reg <= |pop_arr;
        if (|pop_arr) begin
          {out_id_reg, out_address_reg} <= pop_arr[1] ? head_arr[1] : head_arr[0];
          out_channel_reg               <= pop_arr[1];
          last_grant_reg                <= pop_arr[1];
        end
      end
      if (out_valid_reg && in_ready) begin
        beat_count_reg <= beat_count_reg + 16'd1;
      end
    end
  end

  assign out_stall_1 = stall_arr[0];
  assign out_stall_2 = stall_arr[1];
  assign out_address = out_address_reg;
  assign out_id      = out_id_reg;
  assign out_channel = out_channel_reg;
  assign out_valid   = out_valid_reg;
  assign err_seq_1   = err_arr[0];
  assign err_seq_2   = err_arr[1];
  assign beat_count  = beat_count_reg;

endmodule

// File: tb/tb_stream_merger.sv
// Bench for stream_merger: directed scenarios plus random traffic, compared
// every cycle against a queue-based model of the merger.
`ifndef ADDRESS_WIDTH
`define ADDRESS_WIDTH 32
`endif
`ifndef ID_WIDTH
`define ID_WIDTH 8
`endif

module tb_stream_merger;
  localparam int D  = 4;
  localparam int AW = `ADDRESS_WIDTH;
  localparam int IW = `ID_WIDTH;

  typedef struct packed {
    logic [IW-1:0] id;
    logic [AW-1:0] addr;
  } beat_t;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] in_address_1, in_address_2, out_address;
  logic [IW-1:0] in_id_1, in_id_2, out_id;
  logic          in_valid_1, in_valid_2, out_stall_1, out_stall_2;
  logic          out_channel, out_valid, in_ready, err_seq_1, err_seq_2;
  logic [15:0]   beat_count;

  stream_merger #(.FIFO_DEPTH(D)) dut (
    .clk(clk), .reset(reset),
    .in_address_1(in_address_1), .in_id_1(in_id_1), .in_valid_1(in_valid_1), .out_stall_1(out_stall_1),
    .in_address_2(in_address_2), .in_id_2(in_id_2), .in_valid_2(in_valid_2), .out_stall_2(out_stall_2),
    .out_address(out_address), .out_id(out_id), .out_channel(out_channel), .out_valid(out_valid),
    .in_ready(in_ready), .err_seq_1(err_seq_1), .err_seq_2(err_seq_2), .beat_count(beat_count)
  );

  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;
  int failed = 0;

  // Model state
  beat_t         q1[$];
  beat_t         q2[$];
  logic          m_ov;
  beat_t         m_out;
  logic          m_ch;
  logic          m_last;
  logic [IW-1:0] m_ei [2];
  logic [AW-1:0] m_ea [2];
  logic          m_err [2];
  logic [15:0]   m_count;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("stall_1", 64'(out_stall_1), 64'(q1.size() == D));
    chk("stall_2", 64'(out_stall_2), 64'(q2.size() == D));
    chk("out_valid", 64'(out_valid), 64'(m_ov));
    if (m_ov) begin
      chk("out_address", 64'(out_address), 64'(m_out.addr));
      chk("out_id", 64'(out_id), 64'(m_out.id));
      chk("out_channel", 64'(out_channel), 64'(m_ch));
    end
    chk("err_seq_1", 64'(err_seq_1), 64'(m_err[0]));
    chk("err_seq_2", 64'(err_seq_2), 64'(m_err[1]));
    chk("beat_count", 64'(beat_count), 64'(m_count));
  endtask

  task automatic model_push(input int ch, input logic [AW-1:0] a, input logic [IW-1:0] i);
    beat_t b;
    b.id = i;
    b.addr = a;
    if (i != m_ei[ch] || a != m_ea[ch]) m_err[ch] = 1'b1;
    m_ei[ch] = i + IW'(1);
    m_ea[ch] = a + AW'(4);
    if (ch == 0) q1.push_back(b);
    else q2.push_back(b);
  endtask

  // One clock: check current outputs, drive inputs, advance the model across the next edge.
  task automatic cycle(input logic rst, input logic v1, input logic [AW-1:0] a1, input logic [IW-1:0] i1,
                       input logic v2, input logic [AW-1:0] a2, input logic [IW-1:0] i2,
                       input logic rdy, input bit do_chk);
    bit acc1, acc2, has1, has2;
    int pick;
    @(negedge clk);
    if (do_chk) check_all();
    reset = rst;
    in_valid_1 = v1; in_address_1 = a1; in_id_1 = i1;
    in_valid_2 = v2; in_address_2 = a2; in_id_2 = i2;
    in_ready = rdy;
    if (rst) begin
      q1.delete(); q2.delete();
      m_ov = 1'b0; m_out = '0; m_ch = 1'b0; m_last = 1'b1; m_count = '0;
      for (int c = 0; c < 2; c++) begin
        m_ei[c] = '0; m_ea[c] = '0; m_err[c] = 1'b0;
      end
    end else begin
      acc1 = v1 && (q1.size() < D);
      acc2 = v2 && (q2.size() < D);
      if (m_ov && rdy) m_count = m_count + 16'd1;
      if (!m_ov || rdy) begin
        has1 = q1.size() > 0;
        has2 = q2.size() > 0;
        pick = -1;
        if (has1 && has2) pick = (m_last == 1'b1) ? 0 : 1;
        else if (has1) pick = 0;
        else if (has2) pick = 1;
        if (pick == 0) m_out = q1.pop_front();
        else if (pick == 1) m_out = q2.pop_front();
        m_ov = (pick >= 0);
        if (pick >= 0) begin
          m_ch = (pick == 1);
          m_last = (pick == 1);
        end
      end
      if (acc1) model_push(0, a1, i1);
      if (acc2) model_push(1, a2, i2);
    end
  endtask

  task automatic idle(input logic rdy, input int n);
    for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, rdy, 1'b1);
  endtask

  task automatic do_reset();
    cycle(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [IW-1:0] ri1, ri2;
    logic [AW-1:0] ra1, ra2;
    reset = 1'b1;
    in_valid_1 = 0; in_valid_2 = 0; in_ready = 0;
    in_address_1 = '0; in_address_2 = '0; in_id_1 = '0; in_id_2 = '0;

    // Reset state and single-channel stream
    do_reset();
    idle(1'b1, 1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_stall_1", 64'(out_stall_1), 64'd0);
    chk("rst_stall_2", 64'(out_stall_2), 64'd0);
    chk("rst_beat_count", 64'(beat_count), 64'd0);
    for (int k = 0; k < 4; k++)
      cycle(1'b0, 1'b1, AW'(4 * k), IW'(k), 1'b0, '0, '0, 1'b1, 1'b1);
    idle(1'b1, 5);
    chk("s1_beat_count", 64'(beat_count), 64'd4);
    chk("s1_err_seq_1", 64'(err_seq_1), 64'd0);

    // Both channels continuously: alternating grants
    do_reset();
    for (int k = 0; k < 12; k++)
      cycle(1'b0, 1'b1, AW'(4 * k), IW'(k), 1'b1, AW'(4 * k), IW'(k), 1'b1, 1'b1);
    idle(1'b1, 6);

    // Backpressure until ch1 stalls, then drain
    do_reset();
    for (int k = 0; k < 6; k++)
      cycle(1'b0, 1'b1, m_ea[0], m_ei[0], 1'b0, '0, '0, 1'b0, 1'b1);
    idle(1'b0, 2);
    chk("bp_stall_1", 64'(out_stall_1), 64'd1);
    chk("bp_out_id_held", 64'(out_id), 64'd0);
    idle(1'b1, 8);
    chk("bp_beat_count", 64'(beat_count), 64'd5);

    // Sequence error on ch2
    do_reset();
    cycle(1'b0, 1'b0, '0, '0, 1'b1, AW'(0),  IW'(0), 1'b1, 1'b1);
    cycle(1'b0, 1'b0, '0, '0, 1'b1, AW'(4),  IW'(1), 1'b1, 1'b1);
    cycle(1'b0, 1'b0, '0, '0, 1'b1, AW'(12), IW'(3), 1'b1, 1'b1);
    idle(1'b1, 4);
    chk("seq_err_seq_2", 64'(err_seq_2), 64'd1);
    chk("seq_err_seq_1", 64'(err_seq_1), 64'd0);

    // Randomized traffic, occasional sequence glitches
    do_reset();
    for (int k = 0; k < 400; k++) begin
      ri1 = m_ei[0]; ra1 = m_ea[0];
      ri2 = m_ei[1]; ra2 = m_ea[1];
      if ($urandom_range(0, 29) == 0) ri1 = ri1 ^ IW'(1);
      if ($urandom_range(0, 29) == 0) ra2 = AW'($urandom);
      cycle(1'b0, 1'($urandom_range(0, 3) != 0), ra1, ri1,
            1'($urandom_range(0, 3) != 0), ra2, ri2, 1'($urandom_range(0, 2) != 0), 1'b1);
    end
    idle(1'b1, 12);

    // Reset mid-operation with beats buffered
    do_reset();
    for (int k = 0; k < 5; k++)
      cycle(1'b0, 1'b1, m_ea[0], m_ei[0], 1'b0, '0, '0, 1'(k < 2), 1'b1);
    cycle(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b1);
    idle(1'b1, 1);
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_beat_count", 64'(beat_count), 64'd0);
    chk("mid_rst_stall_1", 64'(out_stall_1), 64'd0);
    chk("mid_rst_stall_2", 64'(out_stall_2), 64'd0);
    cycle(1'b0, 1'b1, AW'(0), IW'(0), 1'b0, '0, '0, 1'b1, 1'b1);
    idle(1'b1, 4);
    chk("mid_rst_err_seq_1", 64'(err_seq_1), 64'd0);
    chk("mid_rst_delivered", 64'(beat_count), 64'd1);

    // beat_count wrap
    do_reset();
    for (int n = 0; n < 70000 && m_count != 16'hFFFF; n++)
      cycle(1'b0, 1'b1, m_ea[0], m_ei[0], 1'b0, '0, '0, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, m_ea[0], m_ei[0], 1'b0, '0, '0, 1'b1, 1'b1);
    chk("wrap_ffff", 64'(beat_count), 64'hFFFF);
    cycle(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 1'b1);
    chk("wrap_zero", 64'(beat_count), 64'h0000);
    idle(1'b1, 3);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
